// File: rtl/fcpu_pkg.sv
// Shared CPU types: station layout, field widths, opcode map and the
// opcode-class helpers used by the retirement stage.
package fcpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RSV_ID_W   = 4;
  localparam int INSTR_W    = 6;

  localparam logic [INSTR_W-1:0] OP_NOP    = 6'd0;
  localparam logic [INSTR_W-1:0] OP_ADD    = 6'd1;
  localparam logic [INSTR_W-1:0] OP_SUB    = 6'd2;
  localparam logic [INSTR_W-1:0] OP_LOAD   = 6'd3;
  localparam logic [INSTR_W-1:0] OP_STORE  = 6'd4;
  localparam logic [INSTR_W-1:0] OP_BRANCH = 6'd5;
  localparam logic [INSTR_W-1:0] OP_HALT   = 6'd63;

  typedef struct packed {
    logic [RSV_ID_W-1:0]   station_id;
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [INSTR_W-1:0]    opcode;
    logic [DATA_W-1:0]     content;
  } station_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STORE = 2'd1,
    S_HALT  = 2'd2
  } commit_state_t;

  function automatic logic is_store(input logic [INSTR_W-1:0] opcode);
    return opcode == OP_STORE;
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

  // Everything that is not a store, halt, branch or nop produces a result.
  function automatic logic writes_reg(input logic [INSTR_W-1:0] opcode);
    return !(opcode == OP_STORE || opcode == OP_HALT ||
             opcode == OP_BRANCH || opcode == OP_NOP);
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// ROB-head to commit-unit handshake: the ROB (master) offers its head
// station, the commit unit (slave) signals acceptance.
interface commit_unit_if;
  import fcpu_pkg::*;

  logic     c_valid;
  station_t c_data;
  logic     c_ready;

  modport master (output c_valid, output c_data, input  c_ready);
  modport slave  (input  c_valid, input  c_data, output c_ready);

endinterface

// File: rtl/commit_unit.sv
// In-order retirement stage: writes results back, clears rename tags,
// releases committed stores and freezes on HALT.
module commit_unit
  import fcpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  commit_unit_if.slave          head,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic                  rs_clr_valid,
  output logic [REG_ADDR_W-1:0] rs_clr_reg,
  output logic [RSV_ID_W-1:0]   rs_clr_id,
  output logic                  st_valid,
  output logic [RSV_ID_W-1:0]   st_id,
  input  logic                  st_ready,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_count
);

  commit_state_t state;
  commit_state_t next_state;
  logic          c_ready_int;
  logic          accept;
  logic          wb_fire;
  logic          unused_fields;

  // The ROB only presents stations that are already valid and ready.
  assign unused_fields = &{1'b0, head.c_data.valid, head.c_data.ready};

  assign accept  = head.c_valid & c_ready_int;
  assign wb_fire = accept & writes_reg(head.c_data.opcode) &
                   (head.c_data.dst_reg != '0);

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= S_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        if (accept) begin
          if (is_halt(head.c_data.opcode)) begin
            next_state = S_HALT;
          end else if (is_store(head.c_data.opcode)) begin
            next_state = S_STORE;
          end
        end
      end
      S_STORE: begin
        if (st_ready) begin
          next_state = S_RUN;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RUN;
    endcase
  end

  // Handshake outputs depend on state only, never on c_valid.
  always_comb begin
    c_ready_int = 1'b0;
    st_valid    = 1'b0;
    halted      = 1'b0;
    case (state)
      S_RUN:   c_ready_int = !nrst;
      S_STORE: st_valid    = 1'b1;
      S_HALT:  halted      = 1'b1;
      default: c_ready_int = 1'b0;
    endcase
    head.c_ready = c_ready_int;
  end

  // Result fields only load on a real write-back, so they stay stable otherwise.
  always_ff @(posedge clk) begin
    if (nrst) begin
      rf_we        <= 1'b0;
      rf_addr      <= '0;
      rf_data      <= '0;
      rs_clr_valid <= 1'b0;
      rs_clr_reg   <= '0;
      rs_clr_id    <= '0;
      st_id        <= '0;
      retire_count <= '0;
    end else begin
      rf_we        <= wb_fire;
      rs_clr_valid <= wb_fire;
      if (wb_fire) begin
        rf_addr    <= head.c_data.dst_reg;
        rf_data    <= head.c_data.content;
        rs_clr_reg <= head.c_data.dst_reg;
        rs_clr_id  <= head.c_data.station_id;
      end
      if (accept && is_store(head.c_data.opcode)) begin
        st_id <= head.c_data.station_id;
      end
      if (accept) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed table-driven bench for commit_unit plus hand-written reset,
// halt-recovery and mid-store reset sequences.
module tb_commit_unit;
  import fcpu_pkg::*;

  typedef struct {
    logic                  v;
    logic [RSV_ID_W-1:0]   id;
    logic [REG_ADDR_W-1:0] dst;
    logic [INSTR_W-1:0]    op;
    logic [DATA_W-1:0]     content;
    logic                  st_rdy;
    logic                  e_cready;
    logic                  e_we;
    logic [REG_ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0]     e_data;
    logic [RSV_ID_W-1:0]   e_clr_id;
    logic                  e_st_valid;
    logic [RSV_ID_W-1:0]   e_st_id;
    logic                  e_halted;
    logic [31:0]           e_cnt;
  } vec_t;

  localparam int NVEC = 22;

  logic                  clk;
  logic                  nrst;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic                  rs_clr_valid;
  logic [REG_ADDR_W-1:0] rs_clr_reg;
  logic [RSV_ID_W-1:0]   rs_clr_id;
  logic                  st_valid;
  logic [RSV_ID_W-1:0]   st_id;
  logic                  st_ready;
  logic                  halted;
  logic [31:0]           retire_count;

  int   vectors_applied;
  int   miscompares;
  vec_t vecs [NVEC];

  commit_unit_if cif ();

  commit_unit #(.CNT_W(32)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .head         (cif.slave),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .rs_clr_valid (rs_clr_valid),
    .rs_clr_reg   (rs_clr_reg),
    .rs_clr_id    (rs_clr_id),
    .st_valid     (st_valid),
    .st_id        (st_id),
    .st_ready     (st_ready),
    .halted       (halted),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic v, input int id, input int dst, input logic [INSTR_W-1:0] op,
    input logic [31:0] content, input logic st_rdy, input logic e_cready,
    input logic e_we, input int e_addr, input logic [31:0] e_data, input int e_clr_id,
    input logic e_st_valid, input int e_st_id, input logic e_halted, input int e_cnt);
    vec_t r;
    r.v = v;               r.id = RSV_ID_W'(id);       r.dst = REG_ADDR_W'(dst);
    r.op = op;             r.content = content;        r.st_rdy = st_rdy;
    r.e_cready = e_cready; r.e_we = e_we;              r.e_addr = REG_ADDR_W'(e_addr);
    r.e_data = e_data;     r.e_clr_id = RSV_ID_W'(e_clr_id);
    r.e_st_valid = e_st_valid; r.e_st_id = RSV_ID_W'(e_st_id);
    r.e_halted = e_halted; r.e_cnt = 32'(e_cnt);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [RSV_ID_W-1:0] id,
                       input logic [REG_ADDR_W-1:0] dst, input logic [INSTR_W-1:0] op,
                       input logic [DATA_W-1:0] content, input logic st_rdy);
    cif.c_valid           = v;
    cif.c_data.station_id = id;
    cif.c_data.valid      = 1'b1;
    cif.c_data.ready      = 1'b1;
    cif.c_data.dst_reg    = dst;
    cif.c_data.opcode     = op;
    cif.c_data.content    = content;
    st_ready              = st_rdy;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] e_cnt);
    check({tag, ".rf_we"},        32'(rf_we), 32'd0);
    check({tag, ".rs_clr_valid"}, 32'(rs_clr_valid), 32'd0);
    check({tag, ".st_valid"},     32'(st_valid), 32'd0);
    check({tag, ".halted"},       32'(halted), 32'd0);
    check({tag, ".retire_count"}, retire_count, e_cnt);
  endtask

  // Drive at the falling edge, check c_ready before the rising edge and
  // the registered results at the following falling edge.
  task automatic apply_vector(input int i);
    vec_t t;
    string tag;
    t = vecs[i];
    tag = $sformatf("vec%0d", i);
    drive(t.v, t.id, t.dst, t.op, t.content, t.st_rdy);
    #1;
    check({tag, ".c_ready"}, 32'(cif.c_ready), 32'(t.e_cready));
    @(negedge clk);
    vectors_applied++;
    check({tag, ".rf_we"},        32'(rf_we), 32'(t.e_we));
    check({tag, ".rs_clr_valid"}, 32'(rs_clr_valid), 32'(t.e_we));
    if (t.e_we) begin
      check({tag, ".rf_addr"},    32'(rf_addr), 32'(t.e_addr));
      check({tag, ".rf_data"},    rf_data, t.e_data);
      check({tag, ".rs_clr_reg"}, 32'(rs_clr_reg), 32'(t.e_addr));
      check({tag, ".rs_clr_id"},  32'(rs_clr_id), 32'(t.e_clr_id));
    end
    check({tag, ".st_valid"}, 32'(st_valid), 32'(t.e_st_valid));
    if (t.e_st_valid) begin
      check({tag, ".st_id"}, 32'(st_id), 32'(t.e_st_id));
    end
    check({tag, ".halted"},       32'(halted), 32'(t.e_halted));
    check({tag, ".retire_count"}, retire_count, t.e_cnt);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    nrst            = 1'b1;
    drive(1'b0, '0, '0, OP_NOP, '0, 1'b0);

    //        v   id dst op         content       srdy crdy we addr data          clr stv sid hlt cnt
    vecs[0]  = mk(1, 3, 5, OP_ADD,    32'h1234,     0, 1, 1, 5,  32'h1234,     3,  0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, OP_NOP,    32'h0,        0, 1, 0, 0,  32'h0,        0,  0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 1, OP_ADD,    32'hA0,       0, 1, 1, 1,  32'hA0,       0,  0, 0, 0, 2);
    vecs[3]  = mk(1, 1, 2, OP_SUB,    32'hA1,       0, 1, 1, 2,  32'hA1,       1,  0, 0, 0, 3);
    vecs[4]  = mk(1, 2, 3, OP_ADD,    32'hA2,       0, 1, 1, 3,  32'hA2,       2,  0, 0, 0, 4);
    vecs[5]  = mk(1, 3, 4, OP_LOAD,   32'hA3,       0, 1, 1, 4,  32'hA3,       3,  0, 0, 0, 5);
    vecs[6]  = mk(0, 0, 0, OP_NOP,    32'h0,        0, 1, 0, 0,  32'h0,        0,  0, 0, 0, 5);
    vecs[7]  = mk(1, 2, 0, OP_ADD,    32'hDEAD,     0, 1, 0, 0,  32'h0,        0,  0, 0, 0, 6);
    vecs[8]  = mk(1, 5, 9, OP_LOAD,   32'h55,       0, 1, 1, 9,  32'h55,       5,  0, 0, 0, 7);
    vecs[9]  = mk(1, 6, 3, OP_BRANCH, 32'hBEEF,     0, 1, 0, 0,  32'h0,        0,  0, 0, 0, 8);
    vecs[10] = mk(1, 7, 2, OP_STORE,  32'hCAFE,     0, 1, 0, 0,  32'h0,        0,  1, 7, 0, 9);
    vecs[11] = mk(1, 1, 8, OP_ADD,    32'h11,       0, 0, 0, 0,  32'h0,        0,  1, 7, 0, 9);
    vecs[12] = mk(1, 1, 8, OP_ADD,    32'h11,       0, 0, 0, 0,  32'h0,        0,  1, 7, 0, 9);
    vecs[13] = mk(0, 0, 0, OP_NOP,    32'h0,        0, 0, 0, 0,  32'h0,        0,  1, 7, 0, 9);
    vecs[14] = mk(1, 1, 8, OP_ADD,    32'h11,       1, 0, 0, 0,  32'h0,        0,  0, 0, 0, 9);
    vecs[15] = mk(1, 4, 6, OP_ADD,    32'h66,       0, 1, 1, 6,  32'h66,       4,  0, 0, 0, 10);
    vecs[16] = mk(1, 10, 2, OP_STORE, 32'h0,        1, 1, 0, 0,  32'h0,        0,  1, 10, 0, 11);
    vecs[17] = mk(1, 11, 12, OP_ADD,  32'h77,       1, 0, 0, 0,  32'h0,        0,  0, 0, 0, 11);
    vecs[18] = mk(1, 11, 12, OP_ADD,  32'h77,       0, 1, 1, 12, 32'h77,       11, 0, 0, 0, 12);
    vecs[19] = mk(1, 8, 0, OP_HALT,   32'h0,        0, 1, 0, 0,  32'h0,        0,  0, 0, 1, 13);
    vecs[20] = mk(1, 9, 7, OP_ADD,    32'h99,       0, 0, 0, 0,  32'h0,        0,  0, 0, 1, 13);
    vecs[21] = mk(1, 9, 7, OP_ADD,    32'h99,       1, 0, 0, 0,  32'h0,        0,  0, 0, 1, 13);

    // Two reset cycles: outputs cleared and the head is refused.
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors_applied++;
    check("reset.c_ready", 32'(cif.c_ready), 32'd0);
    check_idle_outputs("reset", 32'd0);
    nrst = 1'b0;
    #1;
    vectors_applied++;
    check("release.c_ready", 32'(cif.c_ready), 32'd1);
    check("release.retire_count", retire_count, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply_vector(i);
    end

    // Reset out of HALT returns to a clean running state.
    drive(1'b0, '0, '0, OP_NOP, '0, 1'b0);
    nrst = 1'b1;
    @(negedge clk);
    vectors_applied++;
    check("halt_reset.c_ready", 32'(cif.c_ready), 32'd0);
    check_idle_outputs("halt_reset", 32'd0);
    nrst = 1'b0;
    #1;
    check("halt_reset.release_c_ready", 32'(cif.c_ready), 32'd1);

    // Reset while a store release is pending drops it for good.
    drive(1'b1, 4'd5, 5'd1, OP_STORE, 32'h5, 1'b0);
    @(negedge clk);
    vectors_applied++;
    check("mid_store.st_valid", 32'(st_valid), 32'd1);
    check("mid_store.st_id", 32'(st_id), 32'd5);
    check("mid_store.retire_count", retire_count, 32'd1);
    drive(1'b0, '0, '0, OP_NOP, '0, 1'b0);
    nrst = 1'b1;
    @(negedge clk);
    vectors_applied++;
    check_idle_outputs("mid_store_reset", 32'd0);
    check("mid_store_reset.st_id", 32'(st_id), 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    vectors_applied++;
    check("after_store_reset.c_ready", 32'(cif.c_ready), 32'd1);
    check_idle_outputs("after_store_reset", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the reorder buffer.
- Accepts the head station (station_t) over a valid/ready handshake and writes its result into the architectural register file.
- Clears the matching rename tag in the register-status table and releases committed stores to the store buffer.
- Stops retirement on a HALT instruction.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- c_valid  in  1  ROB head station valid and ready
- c_data  in  station_t  head station {station_id, valid, ready, dst_reg, opcode, content}
- c_ready  out  1  commit unit accepts the head this cycle
- rf_we  out  1  register-file write enable
- rf_addr  out  REG_ADDR_W  register-file write address
- rf_data  out  DATA_W  register-file write data
- rs_clr_valid  out  1  clear the rename tag in the register-status table
- rs_clr_reg  out  REG_ADDR_W  register whose tag is cleared
- rs_clr_id  out  RSV_ID_W  tag to clear; the status table clears only on a tag match
- st_valid  out  1  committed-store release request
- st_id  out  RSV_ID_W  ROB id of the released store
- st_ready  in  1  store buffer accepts the release
- halted  out  1  HALT retired; commit is frozen
- retire_count  out  CNT_W  number of instructions retired

Behaviour:
- Reset (nrst=1 at a clk edge): all outputs 0, state S_RUN, retire_count=0. This holds even mid-store: st_valid drops, and the pending release is lost by design.
- States: S_RUN, S_STORE, S_HALT.
- c_ready = (state==S_RUN) and not nrst; combinational from state only, never from c_valid.
- Accept = c_valid & c_ready. Classify using package functions on c_data.opcode:
  - is_halt: go to S_HALT.
  - is_store: go to S_STORE.
  - otherwise: write-back.
- Write-back (registered, 1-cycle latency):
  - Triggered when accepted at edge N, with writes_reg(opcode)=1 and dst_reg!=0.
  - In cycle N+1: rf_we=1, rf_addr=dst_reg, rf_data=content, rs_clr_valid=1, rs_clr_reg=dst_reg, rs_clr_id=station_id.
  - Otherwise rf_we=0 and rs_clr_valid=0 in cycle N+1.
  - rf_we and rs_clr_valid are single-cycle pulses.
- Throughput: one non-store instruction per cycle; back-to-back accepts produce back-to-back rf writes.
- S_STORE:
  - st_valid=1 and st_id=station_id from the cycle after accept.
  - Both are held stable until a cycle with st_valid & st_ready; then st_valid=0 next cycle and state returns to S_RUN.
  - c_ready=0 throughout, so minimum store occupancy is 2 cycles.
  - Stores never assert rf_we.
- S_HALT: halted=1 from the cycle after accept; c_ready=0; stays until reset.
- retire_count:
  - +1 on every accept, including stores (counted at accept, not at release) and HALT.
  - Wraps modulo 2^CNT_W.
- Instructions with dst_reg=0 and writes_reg=1 retire with no rf or status side effects. Register 0 is hardwired zero.
- c_data fields are sampled only on accept. Content while c_valid=0 is don't-care.
- No flush input in this revision; the ROB's rob_clear path is tied off.

Decomposition:
- fcpu_pkg gains:
  - opcode-class functions is_store, is_halt, writes_reg (from INSTR_W opcode)
  - typedef commit_state_t {S_RUN, S_STORE, S_HALT}
- station_t, REG_ADDR_W, RSV_ID_W, DATA_W, INSTR_W remain in fcpu_pkg.
- No sub-module; a single FSM plus an output register stage.

Test Plan:
- Reset: nrst=1 for 2 cycles -> all outputs 0, c_ready=0. After nrst=0 -> c_ready=1, retire_count=0.
- ALU commit {id=3, dst_reg=5, content=0x1234} -> next cycle rf_we=1, rf_addr=5, rf_data=0x1234, rs_clr_id=3; retire_count=1; rf_we=0 the following cycle.
- 4 back-to-back ALU stations, ids 0..3, dst 1..4 -> rf_we high 4 consecutive cycles with addrs 1,2,3,4; retire_count=4.
- dst_reg=0 commit -> rf_we=0 and rs_clr_valid=0; retire_count increments by 1.
- Store id=7, st_ready low 3 cycles then high -> st_valid=1, st_id=7 held 4 cycles; c_ready=0 throughout; a next ALU station is accepted the cycle after st_valid falls.
- HALT followed by a valid ALU station -> halted=1, c_ready stays 0, no rf_we for the ALU station. Then nrst=1 -> halted=0, state S_RUN.
